// File: rtl/tlul_mon_pkg.sv
// TL-UL slave monitor shared definitions.
// Error indices, opcode constants and the byte-lane helper.
package tlul_mon_pkg;

  typedef enum logic [3:0] {
    ERR_A_OPCODE = 4'd0,
    ERR_A_PARAM  = 4'd1,
    ERR_A_SIZE   = 4'd2,
    ERR_A_ALIGN  = 4'd3,
    ERR_A_MASK   = 4'd4,
    ERR_A_DUP    = 4'd5,
    ERR_A_STABLE = 4'd6,
    ERR_D_STABLE = 4'd7,
    ERR_D_UNEXP  = 4'd8,
    ERR_D_OPCODE = 4'd9,
    ERR_D_SIZE   = 4'd10,
    ERR_D_PARAM  = 4'd11,
    ERR_OVERFLOW = 4'd12,
    ERR_TIMEOUT  = 4'd13
  } err_e;

  localparam int NERR = 14;

  // errors blamed on the A source vs the D source
  localparam logic [NERR-1:0] A_CLASS = 14'b01_0000_0111_1111;
  localparam logic [NERR-1:0] D_CLASS = 14'b00_1111_1000_0000;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  function automatic logic [7:0] lane_mask(
    input logic [3:0]  size,
    input logic [2:0]  addr,
    input int unsigned dw
  );
    int unsigned lanes;
    int unsigned nb;
    int unsigned off;
    int unsigned m;
    lanes = dw / 8;
    nb = (size > 4'd3) ? 8 : (32'd1 << size);
    if (nb > lanes) nb = lanes;
    off = 32'(addr) & (lanes - 1) & ~(nb - 1);
    m = ((32'd1 << nb) - 1) << off;
    return m[7:0];
  endfunction

endpackage

// File: rtl/tlul_mon_src_entry.sv
// One in-flight table slot for a single source id.
// Holds expected response shape and a saturating age counter.
module tlul_mon_src_entry
  import tlul_mon_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alloc,
  input  logic       retire,
  input  logic [2:0] op_in,
  input  logic [3:0] size_in,
  output logic       valid,
  output logic [2:0] exp_op,
  output logic [3:0] size,
  output logic       tmo_hit
);

  localparam int AGW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [AGW-1:0] AMAX = AGW'(TIMEOUT);
  localparam logic [AGW-1:0] ALAST = AGW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit EN = (TIMEOUT > 0);

  logic [AGW-1:0] age;
  logic           tmo;

  // a beat retiring on the deadline cycle still counts as answered
  assign tmo_hit = EN && valid && !tmo && !alloc && !retire
                && (age == ALAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      exp_op <= '0;
      size   <= '0;
      age    <= '0;
      tmo    <= 1'b0;
    end else if (alloc) begin
      valid  <= 1'b1;
      exp_op <= op_in;
      size   <= size_in;
      age    <= '0;
      tmo    <= 1'b0;
    end else if (retire) begin
      valid  <= 1'b0;
      age    <= '0;
      tmo    <= 1'b0;
    end else if (valid) begin
      if (age != AMAX) age <= age + 1'b1;
      if (tmo_hit) tmo <= 1'b1;
    end
  end

endmodule

// File: rtl/tlul_slave_monitor.sv
// Passive TL-UL slave-port protocol monitor.
// Tracks in-flight sources, checks legality, logs sticky errors.
module tlul_slave_monitor
  import tlul_mon_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RS      = 4,
  parameter int MAX     = 2,
  parameter int TIMEOUT = 256
) (
  input  logic              slave_clock_i,
  input  logic              slave_reset_ni,
  input  logic [2:0]        slave_a_opcode,
  input  logic [2:0]        slave_a_param,
  input  logic [3:0]        slave_a_size,
  input  logic [RS-1:0]     slave_a_source,
  input  logic [AW-1:0]     slave_a_address,
  input  logic [DW/8-1:0]   slave_a_mask,
  input  logic [DW-1:0]     slave_a_data,
  input  logic              slave_a_corrupt,
  input  logic              slave_a_valid,
  input  logic              slave_a_ready,
  input  logic [2:0]        slave_d_opcode,
  input  logic [1:0]        slave_d_param,
  input  logic [3:0]        slave_d_size,
  input  logic [RS-1:0]     slave_d_source,
  input  logic              slave_d_denied,
  input  logic [DW-1:0]     slave_d_data,
  input  logic              slave_d_corrupt,
  input  logic              slave_d_valid,
  input  logic              slave_d_ready,
  input  logic              err_clr_i,
  output logic [NERR-1:0]   err_o,
  output logic              err_pulse_o,
  output logic [NERR-1:0]   first_err_o,
  output logic [RS-1:0]     first_src_o,
  output logic [RS:0]       outstanding_o
);

  localparam int MASK  = DW / 8;
  localparam int MAXSZ = $clog2(DW / 8);
  localparam int NS    = 2 ** RS;
  localparam int AFW   = 3 + 3 + 4 + RS + AW + MASK + DW + 1;
  localparam int DFW   = 3 + 2 + 4 + RS + 1 + DW + 1;

  logic a_fire, d_fire;
  assign a_fire = slave_a_valid & slave_a_ready;
  assign d_fire = slave_d_valid & slave_d_ready;

  logic [NS-1:0] ent_valid, alloc, retire, tmo_hit;
  logic [2:0]    ent_op   [NS];
  logic [3:0]    ent_size [NS];
  logic [2:0]    op_in;

  assign op_in = (slave_a_opcode == OP_GET) ? OP_ACK_DATA : OP_ACK;

  for (genvar i = 0; i < NS; i++) begin : g_ent
    assign alloc[i]  = a_fire && (slave_a_source == RS'(i));
    assign retire[i] = d_fire && ent_valid[i]
                    && (slave_d_source == RS'(i));
    tlul_mon_src_entry #(.TIMEOUT(TIMEOUT)) u_ent (
      .clk     (slave_clock_i),
      .rst_n   (slave_reset_ni),
      .alloc   (alloc[i]),
      .retire  (retire[i]),
      .op_in   (op_in),
      .size_in (slave_a_size),
      .valid   (ent_valid[i]),
      .exp_op  (ent_op[i]),
      .size    (ent_size[i]),
      .tmo_hit (tmo_hit[i])
    );
  end

  logic [AFW-1:0] a_cur, a_q;
  logic [DFW-1:0] d_cur, d_q;
  logic           a_hold_q, d_hold_q;

  assign a_cur = {slave_a_opcode, slave_a_param, slave_a_size,
                  slave_a_source, slave_a_address, slave_a_mask,
                  slave_a_data, slave_a_corrupt};
  assign d_cur = {slave_d_opcode, slave_d_param, slave_d_size,
                  slave_d_source, slave_d_denied, slave_d_data,
                  slave_d_corrupt};

  logic [NERR-1:0] new_err;
  logic [RS-1:0]   src_sel, tmo_src;
  logic [7:0]      lm8;
  logic [MASK-1:0] lm;
  logic [2:0]      am;
  logic            size_ok, op_ok, dup, inc, dec;

  always_comb begin
    new_err = '0;
    lm8     = lane_mask(slave_a_size, slave_a_address[2:0], DW);
    lm      = lm8[MASK-1:0];
    am      = 3'((4'd1 << slave_a_size) - 4'd1);
    size_ok = slave_a_size <= 4'(MAXSZ);
    op_ok   = (slave_a_opcode == OP_GET)
           || (slave_a_opcode == OP_PUT_FULL)
           || (slave_a_opcode == OP_PUT_PART);
    dup     = ent_valid[slave_a_source] && !retire[slave_a_source];
    inc     = a_fire && !dup;
    dec     = d_fire && ent_valid[slave_d_source];
    if (a_fire) begin
      new_err[ERR_A_OPCODE] = !op_ok;
      new_err[ERR_A_PARAM]  = slave_a_param != 3'd0;
      new_err[ERR_A_SIZE]   = !size_ok;
      new_err[ERR_A_ALIGN]  = size_ok && |(slave_a_address[2:0] & am);
      if (op_ok && size_ok) begin
        if (slave_a_opcode == OP_PUT_PART)
          new_err[ERR_A_MASK] = |(slave_a_mask & ~lm);
        else
          new_err[ERR_A_MASK] = slave_a_mask != lm;
      end
      new_err[ERR_A_DUP]    = dup;
      new_err[ERR_OVERFLOW] = inc && !dec
                           && (outstanding_o >= (RS+1)'(MAX));
    end
    new_err[ERR_A_STABLE] = a_hold_q && (!slave_a_valid || a_cur != a_q);
    new_err[ERR_D_STABLE] = d_hold_q && (!slave_d_valid || d_cur != d_q);
    if (d_fire) begin
      if (!ent_valid[slave_d_source]) begin
        new_err[ERR_D_UNEXP] = 1'b1;
      end else begin
        new_err[ERR_D_OPCODE] = slave_d_opcode != ent_op[slave_d_source];
        new_err[ERR_D_SIZE]   = slave_d_size != ent_size[slave_d_source];
        new_err[ERR_D_PARAM]  = slave_d_param != 2'd0;
      end
    end
    new_err[ERR_TIMEOUT] = |tmo_hit;
    tmo_src = '0;
    for (int i = NS - 1; i >= 0; i--)
      if (tmo_hit[i]) tmo_src = RS'(i);
    if (|(new_err & A_CLASS))      src_sel = slave_a_source;
    else if (|(new_err & D_CLASS)) src_sel = slave_d_source;
    else                           src_sel = tmo_src;
  end

  always_ff @(posedge slave_clock_i or negedge slave_reset_ni) begin
    if (!slave_reset_ni) begin
      a_hold_q      <= 1'b0;
      d_hold_q      <= 1'b0;
      a_q           <= '0;
      d_q           <= '0;
      outstanding_o <= '0;
      err_o         <= '0;
      err_pulse_o   <= 1'b0;
      first_err_o   <= '0;
      first_src_o   <= '0;
    end else begin
      a_hold_q <= slave_a_valid & !slave_a_ready;
      d_hold_q <= slave_d_valid & !slave_d_ready;
      a_q      <= a_cur;
      d_q      <= d_cur;
      if (inc && !dec && outstanding_o != (RS+1)'(NS))
        outstanding_o <= outstanding_o + 1'b1;
      else if (dec && !inc && outstanding_o != '0)
        outstanding_o <= outstanding_o - 1'b1;
      err_pulse_o <= |new_err;
      err_o       <= (err_clr_i ? '0 : err_o) | new_err;
      // a clear in the same cycle as a new error still recaptures it
      if (|new_err && (err_clr_i || first_err_o == '0)) begin
        first_err_o <= new_err & (~new_err + NERR'(1));
        first_src_o <= src_sel;
      end else if (err_clr_i) begin
        first_err_o <= '0;
        first_src_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tlul_slave_monitor.sv
// Directed bench for tlul_slave_monitor: A-beat vector table
// plus hand sequences for response, stability, timeout, overflow.
module tb_tlul_slave_monitor;
  import tlul_mon_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  a_opcode, a_param;
  logic [3:0]  a_size, a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        a_corrupt, a_valid, a_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size, d_source;
  logic        d_denied, d_corrupt, d_valid, d_ready;
  logic [31:0] d_data;
  logic        err_clr;
  logic [13:0] err, first_err;
  logic        err_pulse;
  logic [3:0]  first_src;
  logic [4:0]  outstanding;

  int errors = 0;
  int checks = 0;

  tlul_slave_monitor #(
    .AW(32), .DW(32), .RS(4), .MAX(2), .TIMEOUT(8)
  ) dut (
    .slave_clock_i   (clk),
    .slave_reset_ni  (rst_n),
    .slave_a_opcode  (a_opcode),
    .slave_a_param   (a_param),
    .slave_a_size    (a_size),
    .slave_a_source  (a_source),
    .slave_a_address (a_address),
    .slave_a_mask    (a_mask),
    .slave_a_data    (a_data),
    .slave_a_corrupt (a_corrupt),
    .slave_a_valid   (a_valid),
    .slave_a_ready   (a_ready),
    .slave_d_opcode  (d_opcode),
    .slave_d_param   (d_param),
    .slave_d_size    (d_size),
    .slave_d_source  (d_source),
    .slave_d_denied  (d_denied),
    .slave_d_data    (d_data),
    .slave_d_corrupt (d_corrupt),
    .slave_d_valid   (d_valid),
    .slave_d_ready   (d_ready),
    .err_clr_i       (err_clr),
    .err_o           (err),
    .err_pulse_o     (err_pulse),
    .first_err_o     (first_err),
    .first_src_o     (first_src),
    .outstanding_o   (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [3:0]  src;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [13:0] eb(input err_e e);
    return 14'd1 << e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_opcode = 3'd0; a_param = 3'd0; a_size = 4'd0; a_source = 4'd0;
    a_address = 32'd0; a_data = 32'd0; a_mask = 4'd0;
    a_corrupt = 1'b0; a_valid = 1'b0; a_ready = 1'b0;
    d_opcode = 3'd0; d_param = 2'd0; d_size = 4'd0; d_source = 4'd0;
    d_denied = 1'b0; d_data = 32'd0; d_corrupt = 1'b0;
    d_valid = 1'b0; d_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_a(input logic [2:0] op, input logic [2:0] prm,
                       input logic [3:0] sz, input logic [31:0] ad,
                       input logic [3:0] mk, input logic [3:0] src);
    a_opcode = op; a_param = prm; a_size = sz;
    a_address = ad; a_mask = mk; a_source = src;
    a_data = 32'hcafe_0000 | ad;
  endtask

  task automatic a_beat(input logic [2:0] op, input logic [2:0] prm,
                        input logic [3:0] sz, input logic [31:0] ad,
                        input logic [3:0] mk, input logic [3:0] src);
    set_a(op, prm, sz, ad, mk, src);
    a_valid = 1'b1;
    a_ready = 1'b1;
    tick();
    a_valid = 1'b0;
    a_ready = 1'b0;
  endtask

  task automatic d_beat(input logic [2:0] op, input logic [3:0] sz,
                        input logic [3:0] src);
    d_opcode = op; d_param = 2'd0; d_size = sz; d_source = src;
    d_valid = 1'b1;
    d_ready = 1'b1;
    tick();
    d_valid = 1'b0;
    d_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    vecs[0]  = '{OP_GET,      3'd0, 4'd2, 32'h10, 4'hf, 4'd3, 14'd0};
    vecs[1]  = '{OP_PUT_FULL, 3'd0, 4'd2, 32'h00, 4'h3, 4'd1, eb(ERR_A_MASK)};
    vecs[2]  = '{OP_GET,      3'd0, 4'd1, 32'h02, 4'hc, 4'd2, 14'd0};
    vecs[3]  = '{OP_GET,      3'd0, 4'd1, 32'h01, 4'h3, 4'd4, eb(ERR_A_ALIGN)};
    vecs[4]  = '{3'd2,        3'd0, 4'd2, 32'h00, 4'hf, 4'd5, eb(ERR_A_OPCODE)};
    vecs[5]  = '{OP_GET,      3'd1, 4'd2, 32'h00, 4'hf, 4'd6, eb(ERR_A_PARAM)};
    vecs[6]  = '{OP_GET,      3'd0, 4'd3, 32'h00, 4'hf, 4'd7, eb(ERR_A_SIZE)};
    vecs[7]  = '{OP_PUT_PART, 3'd0, 4'd2, 32'h00, 4'h5, 4'd8, 14'd0};
    vecs[8]  = '{OP_PUT_PART, 3'd0, 4'd1, 32'h00, 4'h4, 4'd9, eb(ERR_A_MASK)};
    vecs[9]  = '{OP_GET,      3'd0, 4'd0, 32'h03, 4'h8, 4'd10, 14'd0};
    vecs[10] = '{OP_GET,      3'd0, 4'd0, 32'h03, 4'h1, 4'd11, eb(ERR_A_MASK)};
    vecs[11] = '{OP_PUT_FULL, 3'd0, 4'd1, 32'h03, 4'hc, 4'd12, eb(ERR_A_ALIGN)};

    #3;
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_out", 32'(outstanding), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      reset_dut();
      a_beat(vecs[i].op, vecs[i].param, vecs[i].size, vecs[i].addr,
             vecs[i].mask, vecs[i].src);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_pulse", i), 32'(err_pulse),
          32'(vecs[i].exp != 14'd0));
      chk($sformatf("vec%0d_first", i), 32'(first_err), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_out", i), 32'(outstanding), 32'd1);
      if (vecs[i].exp != 14'd0)
        chk($sformatf("vec%0d_src", i), 32'(first_src), 32'(vecs[i].src));
    end

    // Get src3, AccessAckData five cycles later
    reset_dut();
    a_beat(OP_GET, 3'd0, 4'd2, 32'h10, 4'hf, 4'd3);
    chk("get_out1", 32'(outstanding), 32'd1);
    repeat (4) tick();
    d_beat(OP_ACK_DATA, 4'd2, 4'd3);
    chk("get_out0", 32'(outstanding), 32'd0);
    chk("get_err", 32'(err), 32'd0);

    // pulse lasts one cycle only
    reset_dut();
    a_beat(OP_PUT_FULL, 3'd0, 4'd2, 32'h0, 4'h3, 4'd1);
    tick();
    chk("mask_pulse_low", 32'(err_pulse), 32'd0);
    chk("mask_sticky", 32'(err), 32'(eb(ERR_A_MASK)));

    // A held without ready, address moves
    reset_dut();
    set_a(OP_GET, 3'd0, 4'd2, 32'h10, 4'hf, 4'd0);
    a_valid = 1'b1;
    tick();
    chk("stable_ok", 32'(err), 32'd0);
    a_address = 32'h14;
    tick();
    a_valid = 1'b0;
    chk("stable_err", 32'(err), 32'(eb(ERR_A_STABLE)));

    // unexpected response
    reset_dut();
    d_beat(OP_ACK, 4'd2, 4'd5);
    chk("unexp_err", 32'(err), 32'(eb(ERR_D_UNEXP)));
    chk("unexp_out", 32'(outstanding), 32'd0);
    chk("unexp_src", 32'(first_src), 32'd5);

    // wrong response opcode for a PutFull
    reset_dut();
    a_beat(OP_PUT_FULL, 3'd0, 4'd2, 32'h0, 4'hf, 4'd7);
    d_beat(OP_ACK_DATA, 4'd2, 4'd7);
    chk("dop_err", 32'(err), 32'(eb(ERR_D_OPCODE)));
    chk("dop_out", 32'(outstanding), 32'd0);

    // retire and allocate same source in one cycle
    reset_dut();
    a_beat(OP_GET, 3'd0, 4'd2, 32'h0, 4'hf, 4'd6);
    set_a(OP_GET, 3'd0, 4'd2, 32'h4, 4'hf, 4'd6);
    a_valid = 1'b1; a_ready = 1'b1;
    d_opcode = OP_ACK_DATA; d_size = 4'd2; d_source = 4'd6;
    d_valid = 1'b1; d_ready = 1'b1;
    tick();
    idle_inputs();
    chk("same_err", 32'(err), 32'd0);
    chk("same_out", 32'(outstanding), 32'd1);

    // timeout after exactly 8 cycles
    reset_dut();
    a_beat(OP_GET, 3'd0, 4'd2, 32'h0, 4'hf, 4'd2);
    repeat (7) tick();
    chk("tmo_early", 32'(err), 32'd0);
    tick();
    chk("tmo_err", 32'(err), 32'(eb(ERR_TIMEOUT)));
    chk("tmo_pulse", 32'(err_pulse), 32'd1);
    tick();
    chk("tmo_pulse_once", 32'(err_pulse), 32'd0);
    repeat (3) tick();
    chk("tmo_no_repeat", 32'(err_pulse), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_first", 32'(first_err), 32'd0);

    // three unanswered Gets exceed MAX
    reset_dut();
    a_beat(OP_GET, 3'd0, 4'd2, 32'h0, 4'hf, 4'd0);
    a_beat(OP_GET, 3'd0, 4'd2, 32'h0, 4'hf, 4'd1);
    chk("ovf_none", 32'(err), 32'd0);
    a_beat(OP_GET, 3'd0, 4'd2, 32'h0, 4'hf, 4'd2);
    chk("ovf_err", 32'(err), 32'(eb(ERR_OVERFLOW)));
    chk("ovf_out", 32'(outstanding), 32'd3);
    chk("ovf_src", 32'(first_src), 32'd2);
    rst_n = 1'b0;
    #2;
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_first", 32'(first_err), 32'd0);
    chk("rst_src", 32'(first_src), 32'd0);
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_out", 32'(outstanding), 32'd0);
    rst_n = 1'b1;

    // reset flushes the table mid-transaction
    reset_dut();
    a_beat(OP_GET, 3'd0, 4'd2, 32'h0, 4'hf, 4'd4);
    reset_dut();
    d_beat(OP_ACK_DATA, 4'd2, 4'd4);
    chk("flush_err", 32'(err), 32'(eb(ERR_D_UNEXP)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
